controlador_eventos: RTL and testbench
======================================

# controlador_eventos

- Collects rising-edge events from up to N asynchronous push-button or switch inputs.
- Queues each event as a per-channel pending bit.
- Round-robin arbiter presents one event at a time to the microcontroller's peripheral bus logic over a valid/ack handshake.
- Sits between the board inputs and the memory-mapped peripheral register file. Replaces the per-input one-shot pulse generators so that a CPU polling loop never misses or double-counts a press.

## Interface
Parameters:
- N_CANALES, 4, number of input channels (2..16)
- DEBOUNCE_CICLOS, 3, consecutive stable cycles required before an input change is accepted (only used with DEBOUNCE_EN; 1..255)

Ports (`clk` is the only clock; `rst` is asynchronous, active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- inp  in  N_CANALES  raw asynchronous inputs
- mask_we  in  1  write strobe for the channel enable mask
- mask_in  in  N_CANALES  new mask value, 1 = channel enabled
- ev_ack  in  1  consumer accepts the offered event
- ev_valid  out  1  an event is offered on ev_id
- ev_id  out  $clog2(N_CANALES)  index of the offered channel
- ovf  out  1  sticky: an event was dropped because its channel was already pending
- ovf_clr  in  1  clears ovf

## Operation
- **Input stage, per channel:** 2-flop synchronizer (sync1, sync2, reset 0) feeds a stable value. `est` reset 0.
  - Without DEBOUNCE_EN: `est` = sync2.
  - Edge detect: `pulso` = `est` & ~`est_prev` (`est_prev` reset 0). One cycle per rising edge; falling edges ignored.
- **Pending register `pend[N]`** (reset 0):
  - Set on `pulso[i]` & `mask[i]`.
  - Cleared when channel i is granted.
  - If set and grant hit the same channel in one cycle, set wins: the bit stays 1.
  - If `pulso[i]` & `mask[i]` arrives while `pend[i]` is already 1 and not being granted, the event is dropped and `ovf` is set.
- **Mask** (reset all 1):
  - Loaded from mask_in on mask_we.
  - Channels whose mask bit becomes 0 have their pend bit cleared in the same edge.
- **`ovf`:** set wins over `ovf_clr` when both occur in one cycle.
- **Arbiter FSM:**
  - IDLE: if any pend bit is 1, select the first set bit searching upward from (`ultimo`+1) mod N with wrap.
    - Register ev_id and set ev_valid=1.
    - Clear that pend bit and set `ultimo` = selected index.
    - Go to OFERTA.
  - OFERTA: ev_valid=1; ev_id held constant. On ev_ack=1, drive ev_valid=0 and go to IDLE.
  - ev_ack while in IDLE is ignored.
- **Reset values:** `ultimo` = N-1, so channel 0 has first priority after reset. Reset returns the FSM to IDLE.

## Timing
- Reset (async, immediate): ev_valid=0, ev_id=0, ovf=0, pend=0, mask=all 1, state IDLE. Pending events are discarded. Reset asserted during OFERTA drops ev_valid without waiting for ack.
- Latency, edge E0 = first clock edge sampling inp[i]=1:
  - Without DEBOUNCE_EN: pend[i] set at E2; ev_valid high after E3.
  - With DEBOUNCE_EN: ev_valid high after E(DEBOUNCE_CICLOS+3).
- Ack handshake: ev_ack sampled high at edge A → ev_valid low after A. The next offer can go high after A+1 at the earliest, i.e. one idle cycle between offers.
- ev_valid=1 with no ack holds indefinitely. Further edges on that channel may re-set its pend bit.
- Pulses shorter than 2 clock periods on inp may be missed. This is not an error.

## Configuration
- DEBOUNCE_EN defined:
  - Per-channel counter, $clog2(DEBOUNCE_CICLOS+1) bits, reset 0.
  - The counter increments on every edge where sync2 ≠ `est`, and resets to 0 when sync2 = `est`.
  - On the edge where it would reach DEBOUNCE_CICLOS, `est` toggles and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CICLOS cycles produces no event.
- DEBOUNCE_EN undefined:
  - No counters; `est` = sync2.
  - DEBOUNCE_CICLOS is unused.
  - Every synchronized rising edge is an event.

## Test plan
- Reset, then inp=4'b0001 held, no debounce → ev_valid rises after E3 with ev_id=0. Ack at the next edge → ev_valid=0 one cycle later. No second event while inp stays high.
- inp rises on channels 1, 2 and 3 in the same cycle, ack each offer immediately → ev_id sequence 1, 2, 3; ev_valid low for exactly one cycle between offers.
- Round-robin wrap: grant 3, then channels 0 and 3 pending → next ev_id=0, then 3.
- Channel 2 pending and not granted (channel 1 offer held unacked), second rising edge on inp[2] → ovf=1. After ovf_clr pulse, ovf=0; channel 2 is delivered only once.
- mask_we with mask_in=4'b1110 while channel 0 pending → pend[0] cleared, no offer for 0. Later edges on inp[0] ignored; channel 1 edges still delivered.
- DEBOUNCE_EN with DEBOUNCE_CICLOS=3:
  - A 2-cycle high glitch on inp[1] → no event.
  - A 5-cycle-high inp[1] → ev_valid after E6 with ev_id=1.
  - rst asserted during the resulting OFERTA → ev_valid=0 asynchronously; no offer after reset release.

Source files
------------

// File: rtl/controlador_eventos_if.sv
// Event controller bus: raw inputs, mask programming and the valid/ack event port.
// The slave modport is the controller side; master is the board/CPU side.
interface controlador_eventos_if #(
    parameter int N_CANALES = 4
);
    localparam int ID_W = $clog2(N_CANALES);

    logic [N_CANALES-1:0] inp;
    logic                 mask_we;
    logic [N_CANALES-1:0] mask_in;
    logic                 ev_ack;
    logic                 ev_valid;
    logic [ID_W-1:0]      ev_id;
    logic                 ovf;
    logic                 ovf_clr;

    modport slave (
        input  inp, mask_we, mask_in, ev_ack, ovf_clr,
        output ev_valid, ev_id, ovf
    );

    modport master (
        output inp, mask_we, mask_in, ev_ack, ovf_clr,
        input  ev_valid, ev_id, ovf
    );
endinterface

// File: rtl/controlador_eventos.sv
// Rising-edge event collector with per-channel pending bits and a round-robin
// valid/ack arbiter. Define DEBOUNCE_EN to add per-channel debounce counters.
module controlador_eventos #(
    parameter int N_CANALES       = 4,
    parameter int DEBOUNCE_CICLOS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    controlador_eventos_if.slave  bus
);
    localparam int ID_W = $clog2(N_CANALES);

    if (N_CANALES < 2 || N_CANALES > 16 || DEBOUNCE_CICLOS < 1 || DEBOUNCE_CICLOS > 255) begin : g_cfg_invalida
        $error("controlador_eventos: parameter out of range");
    end

    typedef enum logic {IDLE, OFERTA} estado_t;

    estado_t              estado, estado_sig;
    logic [N_CANALES-1:0] sync1, sync2, est, est_prev, pulso;
    logic [N_CANALES-1:0] mask, mask_eff, pend, set_vec, grant_vec, drop_vec;
    logic [ID_W-1:0]      ev_id_q, ultimo, sel;
    logic                 hay_sel;
    logic                 ovf_q;

    // Input stage: two-flop synchronizer and edge-detector history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            est_prev <= '0;
        end else begin
            sync1    <= bus.inp;
            sync2    <= sync1;
            est_prev <= est;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int                CNT_W   = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CNT_W-1:0]  CNT_FIN = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [CNT_W-1:0] cnt [N_CANALES];

    // est only follows sync2 after DEBOUNCE_CICLOS consecutive differing edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            est <= '0;
            for (int i = 0; i < N_CANALES; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CANALES; i++) begin
                if (sync2[i] != est[i]) begin
                    if (cnt[i] == CNT_FIN) begin
                        est[i] <= ~est[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign est = sync2;
`endif

    // A mask write takes effect on the same edge, both for new events and pending ones
    always_comb begin
        pulso    = est & ~est_prev;
        mask_eff = bus.mask_we ? bus.mask_in : mask;
        set_vec  = pulso & mask_eff;
        drop_vec = set_vec & pend & ~grant_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask  <= '1;
            pend  <= '0;
            ovf_q <= 1'b0;
        end else begin
            mask <= mask_eff;
            pend <= ((pend & ~grant_vec) | set_vec) & mask_eff;
            if (|drop_vec)
                ovf_q <= 1'b1;
            else if (bus.ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        logic [ID_W-1:0] cand;
        sel     = '0;
        hay_sel = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_CANALES; k++) begin
            cand = ID_W'((int'(ultimo) + k) % N_CANALES);
            if (!hay_sel && pend[cand]) begin
                hay_sel = 1'b1;
                sel     = cand;
            end
        end
    end

    always_comb begin
        estado_sig = estado;
        grant_vec  = '0;
        case (estado)
            IDLE: begin
                if (hay_sel) begin
                    estado_sig     = OFERTA;
                    grant_vec[sel] = 1'b1;
                end
            end
            OFERTA: begin
                if (bus.ev_ack) estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado  <= IDLE;
            ev_id_q <= '0;
            ultimo  <= ID_W'(N_CANALES - 1);
        end else begin
            estado <= estado_sig;
            if (estado == IDLE && hay_sel) begin
                ev_id_q <= sel;
                ultimo  <= sel;
            end
        end
    end

    assign bus.ev_valid = (estado == OFERTA);
    assign bus.ev_id    = ev_id_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_controlador_eventos.sv
// Directed bench for controlador_eventos (N_CANALES=4); debounce steps run when DEBOUNCE_EN is defined.
module tb_controlador_eventos;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    controlador_eventos_if #(.N_CANALES(4)) bus ();

    controlador_eventos #(.N_CANALES(4), .DEBOUNCE_CICLOS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_offer(input string tag, input logic [1:0] id);
        chk({tag, "_valid"}, 32'(bus.ev_valid), 32'd1);
        chk({tag, "_id"},    32'(bus.ev_id),    32'(id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.inp     = '0;
        bus.mask_we = 1'b0;
        bus.mask_in = '0;
        bus.ev_ack  = 1'b0;
        bus.ovf_clr = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.ev_valid), 32'd0);
        chk("rst_id",    32'(bus.ev_id),    32'd0);
        chk("rst_ovf",   32'(bus.ovf),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick; tick;

        // Single press on channel 0: offer after E3, ack, no repeat while held
        bus.inp = 4'b0001;
        tick;
        chk("t1_e0", 32'(bus.ev_valid), 32'd0);
        tick; tick;
        chk("t1_e2", 32'(bus.ev_valid), 32'd0);
        tick;
        chk_offer("t1_e3", 2'd0);
        bus.ev_ack = 1'b1;
        tick;
        chk("t1_ack", 32'(bus.ev_valid), 32'd0);
        bus.ev_ack = 1'b0;
        repeat (6) tick;
        chk("t1_no_repeat", 32'(bus.ev_valid), 32'd0);

        // Channels 1..3 rise together, ack held high: 1,2,3 with one idle cycle between
        bus.inp = 4'b1111;
        repeat (3) tick;
        chk("t2_e2", 32'(bus.ev_valid), 32'd0);
        tick;
        chk_offer("t2_first", 2'd1);
        bus.ev_ack = 1'b1;
        tick;
        chk("t2_gap1", 32'(bus.ev_valid), 32'd0);
        tick;
        chk_offer("t2_second", 2'd2);
        tick;
        chk("t2_gap2", 32'(bus.ev_valid), 32'd0);
        tick;
        chk_offer("t2_third", 2'd3);
        tick;
        chk("t2_gap3", 32'(bus.ev_valid), 32'd0);
        bus.ev_ack = 1'b0;
        tick;
        chk("t2_empty", 32'(bus.ev_valid), 32'd0);

        // Wrap: last grant was 3, channels 0 and 3 pending -> 0 then 3
        bus.inp = 4'b0000;
        repeat (4) tick;
        bus.inp = 4'b1001;
        repeat (4) tick;
        chk_offer("t3_wrap0", 2'd0);
        bus.ev_ack = 1'b1;
        tick;
        chk("t3_gap", 32'(bus.ev_valid), 32'd0);
        tick;
        chk_offer("t3_wrap3", 2'd3);
        tick;
        chk("t3_done", 32'(bus.ev_valid), 32'd0);
        bus.ev_ack = 1'b0;

        // Overflow: channel 1 offer held, channel 2 pending gets a second edge
        bus.inp = 4'b0000;
        repeat (4) tick;
        bus.inp = 4'b0110;
        repeat (4) tick;
        chk_offer("t4_hold", 2'd1);
        chk("t4_ovf_pre", 32'(bus.ovf), 32'd0);
        bus.inp = 4'b0010;
        repeat (4) tick;
        bus.inp = 4'b0110;
        tick; tick;
        chk("t4_ovf_e1", 32'(bus.ovf), 32'd0);
        tick;
        chk("t4_ovf_set", 32'(bus.ovf), 32'd1);
        tick;
        chk("t4_ovf_sticky", 32'(bus.ovf), 32'd1);
        bus.ovf_clr = 1'b1;
        tick;
        bus.ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(bus.ovf), 32'd0);
        chk_offer("t4_still", 2'd1);
        bus.ev_ack = 1'b1;
        tick;
        chk("t4_ack1", 32'(bus.ev_valid), 32'd0);
        bus.ev_ack = 1'b0;
        tick;
        chk_offer("t4_ch2", 2'd2);
        bus.ev_ack = 1'b1;
        tick;
        bus.ev_ack = 1'b0;
        chk("t4_ack2", 32'(bus.ev_valid), 32'd0);
        repeat (4) tick;
        chk("t4_once", 32'(bus.ev_valid), 32'd0);
        chk("t4_ovf_end", 32'(bus.ovf), 32'd0);

        // Mask: channel 0 pending behind a channel 3 offer, then masked off
        bus.inp = 4'b0000;
        repeat (4) tick;
        bus.inp = 4'b1001;
        repeat (4) tick;
        chk_offer("t5_ch3", 2'd3);
        bus.mask_we = 1'b1;
        bus.mask_in = 4'b1110;
        tick;
        bus.mask_we = 1'b0;
        bus.ev_ack  = 1'b1;
        tick;
        bus.ev_ack = 1'b0;
        chk("t5_ack", 32'(bus.ev_valid), 32'd0);
        repeat (4) tick;
        chk("t5_masked", 32'(bus.ev_valid), 32'd0);
        bus.inp = 4'b1000;
        repeat (4) tick;
        bus.inp = 4'b1001;
        repeat (6) tick;
        chk("t5_ch0_ignored", 32'(bus.ev_valid), 32'd0);
        bus.inp = 4'b1011;
        repeat (3) tick;
        chk("t5_ch1_e2", 32'(bus.ev_valid), 32'd0);
        tick;
        chk_offer("t5_ch1", 2'd1);
        bus.ev_ack = 1'b1;
        tick;
        bus.ev_ack = 1'b0;
        chk("t5_ch1_ack", 32'(bus.ev_valid), 32'd0);
        bus.inp = 4'b0000;
        repeat (6) tick;

`ifdef DEBOUNCE_EN
        // Two-cycle glitch is filtered; five-cycle press offers after E6
        bus.inp = 4'b0010;
        tick; tick;
        bus.inp = 4'b0000;
        repeat (10) tick;
        chk("t6_glitch", 32'(bus.ev_valid), 32'd0);
        bus.inp = 4'b0010;
        repeat (5) tick;
        bus.inp = 4'b0000;
        chk("t6_e4", 32'(bus.ev_valid), 32'd0);
        tick;
        chk("t6_e5", 32'(bus.ev_valid), 32'd0);
        tick;
        chk_offer("t6_e6", 2'd1);
`else
        bus.inp = 4'b0010;
        repeat (3) tick;
        chk("t6_e2", 32'(bus.ev_valid), 32'd0);
        tick;
        chk_offer("t6_e3", 2'd1);
        bus.inp = 4'b0000;
`endif

        // Asynchronous reset in the middle of an unacked offer
        #3;
        rst = 1'b1;
        #1;
        chk("t7_async_valid", 32'(bus.ev_valid), 32'd0);
        chk("t7_async_id",    32'(bus.ev_id),    32'd0);
        chk("t7_async_ovf",   32'(bus.ovf),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) tick;
        chk("t7_no_offer", 32'(bus.ev_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
